// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: synchronous-read instruction memory with a boot-load write
// port and a single-entry valid/ready fetch response register.
// After reset the block sits in BOOT and accepts load words until one arrives
// with ld_last. It then enters RUN, where memory is write-protected and fetches
// are served with one-cycle latency. Misaligned or out-of-range PCs return
// NOP_INSTR and raise fault flags.
// Optional feature macro: IMEM_RELOAD_EN. When defined, a reload request in RUN
// drains the pending response and returns the block to BOOT.
module imem_fetch_unit #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 256,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(32'h00000013),
  localparam int                IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  output logic              booted,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       PC,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] Instr,
  output logic              fault_misalign,
  output logic              fault_range
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              ld_we;
  logic              accept;
  logic [IDX_W-1:0]  rd_idx;
  logic              misalign;
  logic              out_of_range;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef IMEM_RELOAD_EN
  logic drain, drain_nxt;
`else
  // reload has no function in this build; the name keeps it out of unused-signal reports.
  logic unused_reload;
  assign unused_reload = reload;
`endif

  assign booted       = (state == RUN);
  assign accept       = req_valid && req_ready;
  assign rd_idx       = PC[IDX_W+1:2];
  assign misalign     = (PC[1:0] != 2'b00);
  assign out_of_range = |PC[31:IDX_W+2];

  // State register (plus drain flag when reload is built in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
`ifdef IMEM_RELOAD_EN
      drain <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
`ifdef IMEM_RELOAD_EN
      drain <= drain_nxt;
`endif
    end
  end

  // Next-state, load-enable and request-ready decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    req_ready = 1'b0;
    ld_we     = 1'b0;
`ifdef IMEM_RELOAD_EN
    drain_nxt = drain;
`endif
    case (state)
      BOOT: begin
        ld_we = ld_valid;
`ifdef IMEM_RELOAD_EN
        drain_nxt = 1'b0;
`endif
        if (ld_valid && ld_last) state_nxt = RUN;
      end
      RUN: begin
`ifdef IMEM_RELOAD_EN
        if (drain || reload) begin
          // Stop accepting; leave for BOOT once the held response is gone.
          drain_nxt = 1'b1;
          if (!rsp_valid) begin
            state_nxt = BOOT;
            drain_nxt = 1'b0;
          end
        end else begin
          req_ready = !rsp_valid || rsp_ready;
        end
`else
        req_ready = !rsp_valid || rsp_ready;
`endif
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Instruction storage, written only during BOOT.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive rst_n and must be loaded explicitly.
    if (ld_we) mem[ld_addr] <= ld_data;
  end

  // Single-entry response register: loads on accept, clears when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid      <= 1'b0;
      Instr          <= '0;
      fault_misalign <= 1'b0;
      fault_range    <= 1'b0;
    end else if (accept) begin
      rsp_valid      <= 1'b1;
      fault_misalign <= misalign;
      fault_range    <= out_of_range;
      Instr          <= (misalign || out_of_range) ? NOP_INSTR : mem[rd_idx];
    end else if (rsp_ready) begin
      rsp_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed self-checking bench for imem_fetch_unit (default parameters).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_imem_fetch_unit;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_valid;
  logic [IDX_W-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              reload;
  logic              booted;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       PC;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] Instr;
  logic              fault_misalign;
  logic              fault_range;

  int checks = 0;
  int errors = 0;

  imem_fetch_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .reload         (reload),
    .booted         (booted),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .PC             (PC),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .Instr          (Instr),
    .fault_misalign (fault_misalign),
    .fault_range    (fault_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] ins, input logic mis, input logic rng);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".instr"}, Instr, ins);
    chk({tag, ".mis"}, 32'(fault_misalign), 32'(mis));
    chk({tag, ".rng"}, 32'(fault_range), 32'(rng));
  endtask

  task automatic load(input logic [IDX_W-1:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
  endtask

  initial begin
    rst_n = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    reload = 1'b0; req_valid = 1'b0; PC = '0; rsp_ready = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst.booted", 32'(booted), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.instr", Instr, 32'd0);
    chk("rst.mis", 32'(fault_misalign), 32'd0);
    chk("rst.rng", 32'(fault_range), 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // Boot load with a request pending: never accepted in BOOT
    req_valid = 1'b1; PC = 32'h0;
    load(0, 32'h00500093, 1'b0); #1;
    chk("boot0.req_ready", 32'(req_ready), 32'd0);
    tick();
    load(1, 32'h00a00113, 1'b0); #1;
    chk("boot1.req_ready", 32'(req_ready), 32'd0);
    chk("boot1.booted", 32'(booted), 32'd0);
    tick();
    load(2, 32'h002081b3, 1'b1); req_valid = 1'b0; #1;
    chk("boot2.booted", 32'(booted), 32'd0);
    chk("boot2.rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("boot.done", 32'(booted), 32'd1);

    // Streaming fetch
    req_valid = 1'b1; PC = 32'h0; rsp_ready = 1'b1; #1;
    chk("str.req_ready", 32'(req_ready), 32'd1);
    tick(); chk_rsp("str0", 32'h00500093, 1'b0, 1'b0);
    PC = 32'h4;
    tick(); chk_rsp("str1", 32'h00a00113, 1'b0, 1'b0);
    PC = 32'h8;
    tick(); chk_rsp("str2", 32'h002081b3, 1'b0, 1'b0);
    req_valid = 1'b0;
    tick(); chk("str.drain", 32'(rsp_valid), 32'd0);

    // Backpressure
    req_valid = 1'b1; PC = 32'h4;
    tick(); chk_rsp("bp.first", 32'h00a00113, 1'b0, 1'b0);
    PC = 32'h8; rsp_ready = 1'b0; #1;
    chk("bp.req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp("bp.hold", 32'h00a00113, 1'b0, 1'b0);
      chk("bp.hold.req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1; #1;
    chk("bp.release", 32'(req_ready), 32'd1);
    tick(); chk_rsp("bp.next", 32'h002081b3, 1'b0, 1'b0);
    req_valid = 1'b0;
    tick(); chk("bp.drain", 32'(rsp_valid), 32'd0);

    // Faults and range boundary
    req_valid = 1'b1; PC = 32'h6;
    tick(); chk_rsp("flt.mis", 32'h00000013, 1'b1, 1'b0);
    PC = 32'h400;
    tick(); chk_rsp("flt.rng", 32'h00000013, 1'b0, 1'b1);
    PC = 32'h402;
    tick(); chk_rsp("flt.both", 32'h00000013, 1'b1, 1'b1);
    PC = 32'h3FC;
    tick();
    chk("flt.last.mis", 32'(fault_misalign), 32'd0);
    chk("flt.last.rng", 32'(fault_range), 32'd0);
    PC = 32'hFFFF_FFFC;
    tick(); chk_rsp("flt.top", 32'h00000013, 1'b0, 1'b1);
    req_valid = 1'b0;
    tick();

    // Write protection in RUN
    load(0, 32'hFFFF_FFFF, 1'b1);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("prot.booted", 32'(booted), 32'd1);
    req_valid = 1'b1; PC = 32'h0;
    tick(); chk_rsp("prot.fetch", 32'h00500093, 1'b0, 1'b0);

`ifdef IMEM_RELOAD_EN
    // Reload while a response is held: BOOT only after it is consumed
    req_valid = 1'b0; rsp_ready = 1'b0; reload = 1'b1; #1;
    chk("rl.req_ready", 32'(req_ready), 32'd0);
    tick(); reload = 1'b0;
    chk("rl.hold.booted", 32'(booted), 32'd1);
    chk("rl.hold.valid", 32'(rsp_valid), 32'd1);
    tick();
    chk("rl.hold2.booted", 32'(booted), 32'd1);
    rsp_ready = 1'b1;
    tick();
    chk("rl.consumed", 32'(rsp_valid), 32'd0);
    chk("rl.consumed.booted", 32'(booted), 32'd1);
    tick();
    chk("rl.boot", 32'(booted), 32'd0);
    load(0, 32'h00000073, 1'b1);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("rl.rebooted", 32'(booted), 32'd1);
    req_valid = 1'b1; PC = 32'h0;
    tick(); chk_rsp("rl.fetch", 32'h00000073, 1'b0, 1'b0);
`else
    // Reload has no effect in this build
    reload = 1'b1; PC = 32'h4; #1;
    chk("rl.ignored.req_ready", 32'(req_ready), 32'd1);
    tick(); reload = 1'b0;
    chk("rl.ignored.booted", 32'(booted), 32'd1);
    chk_rsp("rl.ignored.fetch", 32'h00a00113, 1'b0, 1'b0);
    tick(); tick();
    chk("rl.ignored.later", 32'(booted), 32'd1);
`endif

    // Reset while a response is pending
    req_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    chk("mid.pending", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid.booted", 32'(booted), 32'd0);
    chk("mid.instr", Instr, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    req_valid = 1'b1; PC = 32'h0; #1;
    chk("mid.boot.req_ready", 32'(req_ready), 32'd0);
    load(1, 32'h00108093, 1'b0);
    tick();
    chk("mid.boot.booted", 32'(booted), 32'd0);
    load(0, 32'h00500093, 1'b1); req_valid = 1'b0;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("mid.rebooted", 32'(booted), 32'd1);
    req_valid = 1'b1; rsp_ready = 1'b1; PC = 32'h4;
    tick(); chk_rsp("mid.new", 32'h00108093, 1'b0, 1'b0);
    PC = 32'h8;
    tick(); chk_rsp("mid.persist", 32'h002081b3, 1'b0, 1'b0);
    req_valid = 1'b0;
    tick(); chk("mid.drain", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised, synchronous-read instruction memory with a boot-load write port and a valid/ready fetch interface.
- Replaces the fixed 8-word combinational instruction ROM.
- Sits between the PC/fetch stage and decode. Instructions are loaded after reset, then served with one-cycle latency, backpressure, and fault flags for misaligned or out-of-range PCs.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 256, number of instruction words; power of two, minimum 2.
- IDX_W, $clog2(DEPTH), word-index width (derived localparam).
- NOP_INSTR, 32'h00000013, word returned on a faulted fetch (RISC-V addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ld_valid  input  1  boot-load write strobe.
- ld_addr  input  IDX_W  word index to write.
- ld_data  input  DATA_W  word to write.
- ld_last  input  1  qualifies ld_valid; marks the final load word.
- reload  input  1  request return to BOOT (active only with the optional feature).
- booted  output  1  high in RUN state.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  fetch request accepted when high together with req_valid.
- PC  input  32  byte address of the fetch.
- rsp_valid  output  1  Instr and flags valid.
- rsp_ready  input  1  consumer accepts the response.
- Instr  output  DATA_W  fetched instruction.
- fault_misalign  output  1  PC[1:0] != 0 for this response.
- fault_range  output  1  PC >= DEPTH*4 for this response.

Behaviour:
- Reset and clocking:
  - One clock, clk. rst_n is asynchronous, active-low.
  - Reset values: state=BOOT, booted=0, req_ready=0, rsp_valid=0, Instr=0, fault_misalign=0, fault_range=0.
  - Memory contents are not reset.
- BOOT state:
  - req_ready=0.
  - Each cycle with ld_valid=1: mem[ld_addr] <= ld_data.
  - ld_valid=1 with ld_last=1: that word is written and the state becomes RUN on the next edge; booted=1 from that edge.
- RUN state:
  - ld_valid is ignored and memory is write-protected.
  - req_ready = !rsp_valid || rsp_ready. This is a single-entry output register with full throughput (one fetch per cycle under continuous rsp_ready).
- Fetch:
  - A request is accepted on an edge where req_valid && req_ready.
  - On that same edge the response register loads and rsp_valid=1 (one-cycle latency).
  - Index = PC[IDX_W+1:2].
  - fault_misalign = (PC[1:0] != 0).
  - fault_range = (PC[31:IDX_W+2] != 0).
  - If either fault is set, Instr = NOP_INSTR; otherwise Instr = mem[index]. Both flags may be set together.
- Response hold:
  - While rsp_valid && !rsp_ready, Instr and the flags are held stable and no new request is accepted.
  - Accept without a new request: rsp_valid clears on the next edge.
  - Accept with a new request on the same edge: the new response loads and rsp_valid stays 1.
- PC wrap: addresses are never wrapped modulo DEPTH. Any out-of-range PC flags fault_range.
- Reset mid-operation: rst_n low aborts any pending response (rsp_valid=0 immediately) and returns to BOOT. Memory contents persist, but the block still requires a load sequence ending in ld_last.

Optional Feature:
- Macro: IMEM_RELOAD_EN.
- Defined:
  - In RUN, reload=1 sets an internal drain flag and forces req_ready=0.
  - Once rsp_valid=0 (pending response consumed), the state returns to BOOT, booted=0, and loading proceeds as after reset.
  - reload is ignored in BOOT.
- Undefined:
  - The reload port exists but is ignored.
  - RUN is left only by reset.

Test Plan:
- Boot load: after reset, write idx0=32'h00500093, idx1=32'h00a00113, idx2=32'h002081b3 with ld_last on idx2 -> booted=1 one edge later; req_ready=0 throughout BOOT.
- Streaming fetch: PC=0,4,8 on consecutive cycles with rsp_ready=1 -> responses 00500093, 00a00113, 002081b3 on consecutive cycles, each one cycle after acceptance; faults=0.
- Backpressure: accept PC=4, then hold rsp_ready=0 for 3 cycles with req_valid=1, PC=8 -> Instr stays 00a00113, req_ready=0. On rsp_ready=1, PC=8 is accepted and returns 002081b3 next cycle.
- Faults: PC=6 -> Instr=00000013, fault_misalign=1. PC=32'h400 with DEPTH=256 -> fault_range=1, Instr=00000013. PC=32'h402 -> both flags set.
- Protection and reset: in RUN, ld_valid to idx0 with data FFFFFFFF -> a fetch of PC=0 still returns 00500093. Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 asynchronously, booted=0, and the block stays in BOOT until ld_last.
- IMEM_RELOAD_EN: reload pulse while a response is held -> BOOT is entered only after rsp_ready consumes it. Reload with 32'h00000073 at idx0 -> a fetch of PC=0 returns 00000073. Without the macro, reload has no effect.
